// File: rtl/register_file_param_if.sv
// Bus bundle for the parametrised register file: decode-side addresses and write data in,
// registered operands and clear status out.
interface register_file_param_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rw;
  logic [WIDTH-1:0]  dw;
  logic              rwe;
  logic              clr;
  logic [WIDTH-1:0]  crs;
  logic [WIDTH-1:0]  crt;
  logic              busy;

  modport master (
    output rs, rt, rw, dw, rwe, clr,
    input  crs, crt, busy
  );

  modport slave (
    input  rs, rt, rw, dw, rwe, clr,
    output crs, crt, busy
  );
endinterface

// File: rtl/register_file_param.sv
// 2-read/1-write register file with registered reads, optional write bypass, optional
// hardwired-zero r0 and a sequenced bulk-clear engine (one register per cycle).
//
// state | meaning
// IDLE  | normal read/write, clr accepted
// CLEAR | reg[cnt] zeroed each cycle, writes and clr ignored
module register_file_param #(
  parameter int WIDTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic                  clk,
  input logic                  rst,
  register_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  crs_q, crs_d;
  logic [WIDTH-1:0]  crt_q, crt_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic              wr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_ok   = (state_q == IDLE) && bus.rwe && !((ZERO_REG != 0) && (bus.rw == '0));
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (wr_ok) regs_d[bus.rw] = bus.dw;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Without bypass the ports see pre-edge contents, but a register being cleared still reads 0.
  always_comb begin
    if (BYPASS != 0) begin
      crs_d = regs_d[bus.rs];
      crt_d = regs_d[bus.rt];
    end else begin
      crs_d = regs_q[bus.rs];
      crt_d = regs_q[bus.rt];
      if ((state_q == CLEAR) && (cnt_q == bus.rs)) crs_d = '0;
      if ((state_q == CLEAR) && (cnt_q == bus.rt)) crt_d = '0;
    end
    if ((ZERO_REG != 0) && (bus.rs == '0)) crs_d = '0;
    if ((ZERO_REG != 0) && (bus.rt == '0)) crt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      crs_q   <= '0;
      crt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      crs_q   <= crs_d;
      crt_q   <= crt_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.crs  = crs_q;
  assign bus.crt  = crt_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_register_file_param.sv
// Four configurations of the register file driven by shared stimulus and compared every cycle
// against a behavioural model; directed sequences with literal expectations pin the model.
module tb_register_file_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] s_rs = '0, s_rt = '0, s_rw = '0;
  logic [7:0] s_dw = '0;
  logic       s_rwe = 1'b0, s_clr = 1'b0;

  // instance: 0 default, 1 no bypass, 2 zero-reg, 3 8-bit x 8 deep
  int cfg_w[4]    = '{4, 4, 4, 8};
  int cfg_aw[4]   = '{2, 2, 2, 3};
  int cfg_zero[4] = '{0, 0, 1, 0};
  int cfg_byp[4]  = '{1, 0, 1, 1};

  register_file_param_if #(.WIDTH(4), .ADDR_W(2)) i0 ();
  register_file_param_if #(.WIDTH(4), .ADDR_W(2)) i1 ();
  register_file_param_if #(.WIDTH(4), .ADDR_W(2)) i2 ();
  register_file_param_if #(.WIDTH(8), .ADDR_W(3)) i3 ();

  assign i0.rs = s_rs[1:0]; assign i0.rt = s_rt[1:0]; assign i0.rw = s_rw[1:0];
  assign i0.dw = s_dw[3:0]; assign i0.rwe = s_rwe;    assign i0.clr = s_clr;
  assign i1.rs = s_rs[1:0]; assign i1.rt = s_rt[1:0]; assign i1.rw = s_rw[1:0];
  assign i1.dw = s_dw[3:0]; assign i1.rwe = s_rwe;    assign i1.clr = s_clr;
  assign i2.rs = s_rs[1:0]; assign i2.rt = s_rt[1:0]; assign i2.rw = s_rw[1:0];
  assign i2.dw = s_dw[3:0]; assign i2.rwe = s_rwe;    assign i2.clr = s_clr;
  assign i3.rs = s_rs;      assign i3.rt = s_rt;      assign i3.rw = s_rw;
  assign i3.dw = s_dw;      assign i3.rwe = s_rwe;    assign i3.clr = s_clr;

  register_file_param #(.WIDTH(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .bus(i0));
  register_file_param #(.WIDTH(4), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  register_file_param #(.WIDTH(4), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) dut2 (.clk(clk), .rst(rst), .bus(i2));
  register_file_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut3 (.clk(clk), .rst(rst), .bus(i3));

  logic [7:0] o_crs[4];
  logic [7:0] o_crt[4];
  logic       o_busy[4];
  assign o_crs[0] = {4'b0, i0.crs}; assign o_crt[0] = {4'b0, i0.crt}; assign o_busy[0] = i0.busy;
  assign o_crs[1] = {4'b0, i1.crs}; assign o_crt[1] = {4'b0, i1.crt}; assign o_busy[1] = i1.busy;
  assign o_crs[2] = {4'b0, i2.crs}; assign o_crt[2] = {4'b0, i2.crt}; assign o_busy[2] = i2.busy;
  assign o_crs[3] = i3.crs;         assign o_crt[3] = i3.crt;         assign o_busy[3] = i3.busy;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: a clear is "cycles left"; register being cleared = depth - left.
  logic [7:0] m_reg[4][8];
  logic [7:0] m_crs[4];
  logic [7:0] m_crt[4];
  int         m_left[4];
  logic [7:0] nr[8];

  function automatic logic [7:0] rd_val(input int d, input int a, input logic [7:0] nv,
                                        input logic [7:0] ov, input bit cleared_now);
    if (cfg_zero[d] != 0 && a == 0) return 8'h00;
    if (cfg_byp[d] != 0) return nv;
    return cleared_now ? 8'h00 : ov;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        for (int i = 0; i < 8; i++) m_reg[d][i] = 8'h00;
        m_crs[d]  = 8'h00;
        m_crt[d]  = 8'h00;
        m_left[d] = 0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        int depth, a_s, a_t, a_w, idx;
        logic [7:0] mask;
        bit clearing;
        depth    = 1 << cfg_aw[d];
        mask     = 8'((1 << cfg_w[d]) - 1);
        a_s      = int'(s_rs) % depth;
        a_t      = int'(s_rt) % depth;
        a_w      = int'(s_rw) % depth;
        clearing = (m_left[d] > 0);
        idx      = depth - m_left[d];
        for (int i = 0; i < 8; i++) nr[i] = m_reg[d][i];
        if (!clearing && s_rwe && !(cfg_zero[d] != 0 && a_w == 0)) nr[a_w] = s_dw & mask;
        if (clearing) nr[idx] = 8'h00;
        m_crs[d] = rd_val(d, a_s, nr[a_s], m_reg[d][a_s], clearing && idx == a_s);
        m_crt[d] = rd_val(d, a_t, nr[a_t], m_reg[d][a_t], clearing && idx == a_t);
        for (int i = 0; i < 8; i++) m_reg[d][i] = nr[i];
        if (clearing) m_left[d] = m_left[d] - 1;
        else if (s_clr) m_left[d] = depth;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("dut%0d crs", d), o_crs[d], m_crs[d]);
        chk($sformatf("dut%0d crt", d), o_crt[d], m_crt[d]);
        chk($sformatf("dut%0d busy", d), {7'b0, o_busy[d]}, {7'b0, m_left[d] > 0});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset crs", o_crs[0], 8'h00);
    chk("reset busy", {7'b0, o_busy[3]}, 8'h00);
    rst = 1'b0;

    for (int a = 0; a < 4; a++) begin
      s_rs = 3'(a); s_rt = 3'(a);
      cyc();
      chk("init read crs", o_crs[0], 8'h00);
      chk("init read crt", o_crt[0], 8'h00);
    end

    s_rwe = 1'b1; s_rw = 3'd2; s_dw = 8'h0A; s_rs = 3'd0; s_rt = 3'd0;
    cyc();
    s_rwe = 1'b0; s_rs = 3'd2; s_rt = 3'd2;
    cyc();
    chk("r2 crs", o_crs[0], 8'h0A);
    chk("r2 crt", o_crt[0], 8'h0A);

    s_rwe = 1'b1; s_rw = 3'd1; s_dw = 8'h05; s_rs = 3'd1; s_rt = 3'd0;
    cyc();
    chk("bypass on", o_crs[0], 8'h05);
    chk("bypass off", o_crs[1], 8'h00);

    s_rw = 3'd0; s_dw = 8'h0F; s_rs = 3'd0; s_rt = 3'd0;
    cyc();
    chk("zero bypass", o_crs[2], 8'h00);
    chk("nonzero bypass", o_crs[0], 8'h0F);
    s_rwe = 1'b0;
    cyc();
    chk("zero read", o_crt[2], 8'h00);

    for (int a = 0; a < 4; a++) begin
      s_rwe = 1'b1; s_rw = 3'(a); s_dw = 8'(a + 1);
      cyc();
    end
    s_rwe = 1'b0; s_clr = 1'b1;
    cyc();
    chk("clr busy 1", {7'b0, o_busy[0]}, 8'h01);
    s_clr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      s_rwe = 1'b1; s_rw = 3'd3; s_dw = 8'h07; s_clr = (k == 2);
      cyc();
      chk("clr busy held", {7'b0, o_busy[0]}, 8'h01);
    end
    cyc();
    chk("clr busy end", {7'b0, o_busy[0]}, 8'h00);
    s_rwe = 1'b0; s_clr = 1'b0;
    for (int a = 0; a < 4; a++) begin
      s_rs = 3'(a); s_rt = 3'(a);
      cyc();
      chk("post clr crs", o_crs[0], 8'h00);
      chk("post clr crt", o_crt[0], 8'h00);
    end

    repeat (8) cyc();
    s_rwe = 1'b1; s_rw = 3'd5; s_dw = 8'hC3; s_rs = 3'd5;
    cyc();
    chk("w8 bypass", o_crs[3], 8'hC3);
    s_rwe = 1'b0; s_clr = 1'b1;
    cyc();
    s_clr = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("async busy", {7'b0, o_busy[3]}, 8'h00);
    chk("async crs", o_crs[3], 8'h00);
    chk("async crt", o_crt[3], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    s_rwe = 1'b1; s_rw = 3'd5; s_dw = 8'h9C; s_rs = 3'd5; s_rt = 3'd4;
    cyc();
    s_rwe = 1'b0;
    cyc();
    chk("after rst crs", o_crs[3], 8'h9C);
    chk("after rst crt", o_crt[3], 8'h00);

    for (int n = 0; n < 3000; n++) begin
      s_rs  = 3'($urandom_range(0, 7));
      s_rt  = 3'($urandom_range(0, 7));
      s_rw  = 3'($urandom_range(0, 7));
      s_dw  = 8'($urandom_range(0, 255));
      s_rwe = ($urandom_range(0, 1) == 1);
      s_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
